// File: rtl/column_stream_sel_pkg.sv
// Shared definitions for the column streamer: FSM state encoding and the
// default geometry of the column buffer.
package column_stream_sel_pkg;

    localparam int DEF_COL_W    = 99;
    localparam int DEF_NUM_COLS = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/column_mux_n.sv
// Combinational NUM_COLS:1 column selector. An index beyond the last column
// selects all-zero data.
module column_mux_n
    import column_stream_sel_pkg::*;
#(
    parameter int COL_W    = DEF_COL_W,
    parameter int NUM_COLS = DEF_NUM_COLS
) (
    input  logic [NUM_COLS*COL_W-1:0]     cols_i,
    input  logic [$clog2(NUM_COLS)-1:0]   sel_i,
    output logic [COL_W-1:0]              col_o
);

    localparam int SEL_W = $clog2(NUM_COLS);

    // NOTE: the default assignment ahead of the loop keeps this block free of latches.
    always_comb begin
        col_o = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            if (sel_i == SEL_W'(k)) begin
                col_o = cols_i[k*COL_W +: COL_W];
            end
        end
    end

endmodule

// File: rtl/column_stream_sel.sv
// Captures a set of NUM_COLS columns on load and streams them one per
// accepted beat, starting at a chosen column and wrapping around.
module column_stream_sel
    import column_stream_sel_pkg::*;
#(
    parameter int COL_W    = DEF_COL_W,
    parameter int NUM_COLS = DEF_NUM_COLS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [NUM_COLS*COL_W-1:0]     data_in,
    input  logic [$clog2(NUM_COLS)-1:0]   start_col,
    input  logic                          ready_in,
    output logic [COL_W-1:0]              data_out,
    output logic [$clog2(NUM_COLS)-1:0]   col_idx,
    output logic                          valid_out,
    output logic                          last,
    output logic                          busy,
    output logic                          done
);

    localparam int                SEL_W     = $clog2(NUM_COLS);
    localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(NUM_COLS - 1);
    localparam logic [SEL_W:0]    NUM_COLS_X = (SEL_W + 1)'(NUM_COLS);

    state_e                       state_q;
    logic [NUM_COLS*COL_W-1:0]    cols_q;
    logic [SEL_W-1:0]             idx_q;
    logic [SEL_W-1:0]             beat_q;
    logic                         done_q;

    logic [SEL_W-1:0]             start_idx;
    logic [SEL_W-1:0]             next_idx;
    logic                         streaming;
    logic                         last_beat;

    // Out-of-range start columns restart the set at column 0.
    assign start_idx = ({1'b0, start_col} < NUM_COLS_X) ? start_col : '0;
    assign next_idx  = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
    assign streaming = (state_q == STREAM);
    assign last_beat = streaming && (beat_q == LAST_IDX);

    assign valid_out = streaming;
    assign busy      = streaming;
    assign last      = last_beat;
    assign col_idx   = idx_q;
    assign done      = done_q;

    column_mux_n #(
        .COL_W    (COL_W),
        .NUM_COLS (NUM_COLS)
    ) u_mux (
        .cols_i (cols_q),
        .sel_i  (idx_q),
        .col_o  (data_out)
    );

    // NOTE: column storage is reset along with the control state so the
    // visible data returns to zero the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cols_q  <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        cols_q  <= data_in;
                        idx_q   <= start_idx;
                        beat_q  <= '0;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (ready_in) begin
                        if (last_beat) begin
                            done_q <= 1'b1;
                            // A load on the final transfer chains the next set with no bubble.
                            if (load) begin
                                cols_q <= data_in;
                                idx_q  <= start_idx;
                                beat_q <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            idx_q  <= next_idx;
                            beat_q <= beat_q + SEL_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/column_stream_sel.md
COLUMN_STREAM_SEL -- requirements
Module: column_stream_sel

Interface
REQ-001 Parameter COL_W, default 99, bit width of one buffer column; SHALL be >= 1.
REQ-002 Parameter NUM_COLS, default 4, number of columns held; SHALL be >= 2.
REQ-003 Derived localparam SEL_W = clog2(NUM_COLS), the index width.
REQ-004 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 LOAD  input  1  capture request for a new set of columns.
REQ-007 DATA_IN  input  NUM_COLS*COL_W  packed columns; column k SHALL occupy bits [k*COL_W +: COL_W].
REQ-008 START_COL  input  SEL_W  first column to emit, sampled with LOAD.
REQ-009 READY_IN  input  1  downstream accepts the current column.
REQ-010 DATA_OUT  output  COL_W  current column data.
REQ-011 COL_IDX  output  SEL_W  index of the column on DATA_OUT.
REQ-012 VALID_OUT  output  1  DATA_OUT/COL_IDX valid.
REQ-013 LAST  output  1  current beat is the final beat of the set.
REQ-014 BUSY  output  1  high while a set is streaming.
REQ-015 DONE  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-016 FSM SHALL have two states: IDLE and STREAM.
REQ-017 In IDLE with LOAD=1, the block SHALL register all NUM_COLS columns, set the index to START_COL, clear the beat counter, and enter STREAM next cycle.
REQ-018 START_COL >= NUM_COLS SHALL be treated as 0.
REQ-019 In STREAM, VALID_OUT=1, BUSY=1, DATA_OUT SHALL equal stored column COL_IDX; in IDLE, VALID_OUT=0, BUSY=0, LAST=0.
REQ-020 A beat SHALL transfer only on a cycle with VALID_OUT=1 and READY_IN=1; the index then SHALL advance by 1, wrapping from NUM_COLS-1 to 0.
REQ-021 With READY_IN=0, DATA_OUT, COL_IDX, LAST SHALL hold unchanged.
REQ-022 LAST SHALL be 1 exactly when the beat counter equals NUM_COLS-1 in STREAM.
REQ-023 On transfer of the LAST beat, DONE SHALL pulse high for the following cycle and the FSM SHALL return to IDLE, unless REQ-024 applies.
REQ-024 LAST-beat transfer coinciding with LOAD=1 SHALL capture the new set and remain in STREAM (back-to-back, zero bubble); DONE SHALL still pulse.
REQ-025 LOAD in STREAM on any non-final-transfer cycle SHALL be ignored; stored data SHALL not change.
REQ-026 First VALID_OUT SHALL appear exactly one cycle after the LOAD cycle; throughput SHALL be one column per cycle with READY_IN held high.
REQ-027 Stored column registers SHALL change only on accepted LOAD.

Reset
REQ-028 RST_N=0 SHALL immediately force IDLE, index 0, beat counter 0, VALID_OUT=0, LAST=0, BUSY=0, DONE=0, DATA_OUT=0 (column storage cleared).
REQ-029 Reset mid-stream SHALL abandon the set without a DONE pulse; first LOAD after release SHALL behave as from power-up.

Structure
REQ-030 Shared header SHALL hold FSM state encodings and default COL_W/NUM_COLS values; nothing else.
REQ-031 One sub-module, column_mux_n, SHALL implement the parametrised combinational NUM_COLS:1 column select; all sequential logic stays in the top.

Verification
REQ-032 COL_W=99, NUM_COLS=4, columns A,B,C,D, START_COL=0, READY_IN=1 -> A,B,C,D on cycles 1-4 after LOAD, LAST on D, DONE on cycle 5.
REQ-033 START_COL=2 -> C,D,A,B with COL_IDX 2,3,0,1; LAST on B.
REQ-034 READY_IN=0 for 3 cycles on beat 2 -> DATA_OUT holds B, COL_IDX=1, no advance; resumes C,D.
REQ-035 LOAD with new set E..H on D's transfer cycle -> E follows D next cycle, DONE pulses once, BUSY stays high.
REQ-036 LOAD asserted on beat 2 (non-final) -> ignored, output stays A..D; START_COL=5 with NUM_COLS=8 -> starts at 5; START_COL=7 with NUM_COLS=6 -> starts at 0.
REQ-037 RST_N low on beat 3 -> all outputs 0 immediately, no DONE; next LOAD streams normally.
